// File: rtl/sm_input_debounce.sv
// Multi-bit switch/key debouncer: two-flop synchronizer per bit, per-bit
// stability counter, registered debounced level plus one-cycle edge pulses.
module sm_input_debounce #(
   parameter int               WIDTH     = 8,
   parameter int               DEBOUNCE  = 50000,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clkIn,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sw_in,
   output logic [WIDTH-1:0] sw_out,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall,
   output logic             sw_changed
);

   localparam int             CW      = $clog2(DEBOUNCE + 1);
   localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE - 1);

   logic [WIDTH-1:0] s1_q, s1_d;
   logic [WIDTH-1:0] s2_q, s2_d;
   logic [WIDTH-1:0] state_q, state_d;
   logic [WIDTH-1:0] rise_q, rise_d;
   logic [WIDTH-1:0] fall_q, fall_d;
   logic             changed_q, changed_d;
   logic [CW-1:0]    cnt_q [WIDTH];
   logic [CW-1:0]    cnt_d [WIDTH];

   always_comb begin
      s1_d    = sw_in;
      s2_d    = s1_q;
      state_d = state_q;
      rise_d  = '0;
      fall_d  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
         // Any sample agreeing with the accepted level restarts the count.
         if (s2_q[i] != state_q[i]) begin
            if (cnt_q[i] >= CNT_MAX) begin
               state_d[i] = s2_q[i];
               rise_d[i]  = s2_q[i];
               fall_d[i]  = ~s2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
      changed_d = |{rise_d, fall_d};
   end

   always_ff @(posedge clkIn) begin
      if (!rst_n) begin
         s1_q      <= RESET_VAL;
         s2_q      <= RESET_VAL;
         state_q   <= RESET_VAL;
         rise_q    <= '0;
         fall_q    <= '0;
         changed_q <= 1'b0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         state_q   <= state_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         changed_q <= changed_d;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign sw_out     = state_q;
   assign sw_rise    = rise_q;
   assign sw_fall    = fall_q;
   assign sw_changed = changed_q;

endmodule

// File: tb/tb_sm_input_debounce.sv
// Directed bench for sm_input_debounce: vector table at DEBOUNCE=4, hand
// sequences at DEBOUNCE=1 with non-zero reset value, and one default-parameter run.
module tb_sm_input_debounce;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // DUT A: WIDTH=8, DEBOUNCE=4, RESET_VAL=0
   logic       a_rst_n, a_chg;
   logic [7:0] a_in, a_out, a_rise, a_fall;
   sm_input_debounce #(.WIDTH(8), .DEBOUNCE(4), .RESET_VAL(8'h00)) u_a (
      .clkIn(clk), .rst_n(a_rst_n), .sw_in(a_in), .sw_out(a_out),
      .sw_rise(a_rise), .sw_fall(a_fall), .sw_changed(a_chg));

   // DUT B: WIDTH=4, DEBOUNCE=1, RESET_VAL=4'b0101
   logic       b_rst_n, b_chg;
   logic [3:0] b_in, b_out, b_rise, b_fall;
   sm_input_debounce #(.WIDTH(4), .DEBOUNCE(1), .RESET_VAL(4'b0101)) u_b (
      .clkIn(clk), .rst_n(b_rst_n), .sw_in(b_in), .sw_out(b_out),
      .sw_rise(b_rise), .sw_fall(b_fall), .sw_changed(b_chg));

   // DUT C: default parameters
   logic       c_rst_n, c_chg;
   logic [7:0] c_in, c_out, c_rise, c_fall;
   sm_input_debounce u_c (
      .clkIn(clk), .rst_n(c_rst_n), .sw_in(c_in), .sw_out(c_out),
      .sw_rise(c_rise), .sw_fall(c_fall), .sw_changed(c_chg));

   typedef struct {
      logic       rst_n;
      logic [7:0] sw_in;
      logic [7:0] exp_out;
      logic [7:0] exp_rise;
      logic [7:0] exp_fall;
      logic       exp_chg;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic [7:0] i, input logic [7:0] o,
                      input logic [7:0] ri, input logic [7:0] fa, input logic c);
      vec_t v;
      v.rst_n = r; v.sw_in = i; v.exp_out = o;
      v.exp_rise = ri; v.exp_fall = fa; v.exp_chg = c;
      vecs.push_back(v);
   endtask

   // n quiet cycles: reset released, no pulses expected
   task automatic hold(input int n, input logic [7:0] i, input logic [7:0] o);
      for (int k = 0; k < n; k++) add(1'b1, i, o, 8'h00, 8'h00, 1'b0);
   endtask

   task automatic step_b(input string name, input logic r, input logic [3:0] i,
                         input logic [3:0] o, input logic [3:0] ri,
                         input logic [3:0] fa, input logic c);
      b_rst_n = r;
      b_in    = i;
      @(posedge clk);
      #1;
      chk({name, " out"},  32'(b_out),  32'(o));
      chk({name, " rise"}, 32'(b_rise), 32'(ri));
      chk({name, " fall"}, 32'(b_fall), 32'(fa));
      chk({name, " chg"},  32'(b_chg),  32'(c));
   endtask

   initial begin
      a_rst_n = 1'b0; a_in = 8'h00;
      b_rst_n = 1'b0; b_in = 4'h0;
      c_rst_n = 1'b0; c_in = 8'h00;

      // reset
      add(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
      add(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
      // clean rise: sw_out changes on the 6th edge
      hold(5, 8'h01, 8'h00);
      add(1'b1, 8'h01, 8'h01, 8'h01, 8'h00, 1'b1);
      hold(2, 8'h01, 8'h01);
      // clean fall
      hold(5, 8'h00, 8'h01);
      add(1'b1, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1);
      hold(2, 8'h00, 8'h00);
      // 3-clock glitch rejected
      hold(3, 8'h01, 8'h00);
      hold(6, 8'h00, 8'h00);
      // 4-clock pulse is just long enough; then it falls back
      hold(4, 8'h01, 8'h00);
      hold(1, 8'h00, 8'h00);
      add(1'b1, 8'h00, 8'h01, 8'h01, 8'h00, 1'b1);
      hold(3, 8'h00, 8'h01);
      add(1'b1, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1);
      hold(2, 8'h00, 8'h00);
      // bounce on bit3: 1,0,1,0,1 then held
      hold(1, 8'h08, 8'h00);
      hold(1, 8'h00, 8'h00);
      hold(1, 8'h08, 8'h00);
      hold(1, 8'h00, 8'h00);
      hold(5, 8'h08, 8'h00);
      add(1'b1, 8'h08, 8'h08, 8'h08, 8'h00, 1'b1);
      hold(2, 8'h08, 8'h08);
      // bring up 0x0F, then swap to 0xF0 in one cycle
      hold(5, 8'h0F, 8'h08);
      add(1'b1, 8'h0F, 8'h0F, 8'h07, 8'h00, 1'b1);
      hold(2, 8'h0F, 8'h0F);
      hold(5, 8'hF0, 8'h0F);
      add(1'b1, 8'hF0, 8'hF0, 8'hF0, 8'h0F, 1'b1);
      hold(3, 8'hF0, 8'hF0);
      // reset clears a non-zero state, then reset on 4th edge of a count
      add(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
      hold(3, 8'h80, 8'h00);
      add(1'b0, 8'h80, 8'h00, 8'h00, 8'h00, 1'b0);
      hold(5, 8'h80, 8'h00);
      add(1'b1, 8'h80, 8'h80, 8'h80, 8'h00, 1'b1);
      hold(2, 8'h80, 8'h80);

      for (int i = 0; i < vecs.size(); i++) begin
         a_rst_n = vecs[i].rst_n;
         a_in    = vecs[i].sw_in;
         @(posedge clk);
         #1;
         chk($sformatf("a[%0d] sw_out", i),  32'(a_out),  32'(vecs[i].exp_out));
         chk($sformatf("a[%0d] sw_rise", i), 32'(a_rise), 32'(vecs[i].exp_rise));
         chk($sformatf("a[%0d] sw_fall", i), 32'(a_fall), 32'(vecs[i].exp_fall));
         chk($sformatf("a[%0d] sw_chg", i),  32'(a_chg),  32'(vecs[i].exp_chg));
      end

      // DEBOUNCE=1, RESET_VAL=0101: release with sw_in=0 falls after 3 edges
      step_b("b rst",   1'b0, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 1'b0);
      step_b("b rel1",  1'b1, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 1'b0);
      step_b("b rel2",  1'b1, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 1'b0);
      step_b("b rel3",  1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0101, 1'b1);
      step_b("b rel4",  1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      // single-clock pulse is accepted both ways
      step_b("b p1",    1'b1, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      step_b("b p2",    1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      step_b("b p3",    1'b1, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 1'b1);
      step_b("b p4",    1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 1'b1);
      step_b("b p5",    1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

      // default parameters: 0x00 -> 0x3F lands on edge 50002
      c_rst_n = 1'b0;
      c_in    = 8'h00;
      @(posedge clk);
      #1;
      chk("c rst out", 32'(c_out), 32'h00);
      c_rst_n = 1'b1;
      c_in    = 8'h3F;
      repeat (50001) @(posedge clk);
      #1;
      chk("c 50001 out",  32'(c_out),  32'h00);
      chk("c 50001 rise", 32'(c_rise), 32'h00);
      @(posedge clk);
      #1;
      chk("c 50002 out",  32'(c_out),  32'h3F);
      chk("c 50002 rise", 32'(c_rise), 32'h3F);
      chk("c 50002 chg",  32'(c_chg),  32'h1);
      @(posedge clk);
      #1;
      chk("c 50003 rise", 32'(c_rise), 32'h00);
      chk("c 50003 chg",  32'(c_chg),  32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
